// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_arb_ctrl serializer slice.
package shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the pointer register lives in the caller.
module rr_arb2
    import shift_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       rr,
    input  logic       window,
    output logic [1:0] ready,
    output logic       grant_id
);

    // A lone valid requester wins; contention (or no request) falls back to the pointer.
    always_comb begin
        grant_id = rr;
        if (valid == 2'b01) begin
            grant_id = SRC0;
        end else if (valid == 2'b10) begin
            grant_id = SRC1;
        end
        ready = {window && (grant_id == SRC1), window && (grant_id == SRC0)};
    end

endmodule

// File: rtl/shift_arb_ctrl.sv
// Round-robin scheduler feeding one LSB-first parallel-to-serial shifter from two requesters.
module shift_arb_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             sout_src,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               src_q, src_d;
    logic               rr_q, rr_d;

    logic               at_last;
    logic               window;
    logic [1:0]         ready;
    logic               grant_id;
    logic               accept;

    assign at_last = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    // Reset closes the window so neither requester sees ready while rst is high.
    assign window  = !rst && ((state_q == ST_IDLE) || at_last);

    rr_arb2 u_arb (
        .valid    ({req1_valid, req0_valid}),
        .rr       (rr_q),
        .window   (window),
        .ready    (ready),
        .grant_id (grant_id)
    );

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign accept     = (req0_valid && ready[0]) || (req1_valid && ready[1]);

    // Shift/advance each SHIFT cycle; an accept overrides with a fresh load.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        rr_d    = rr_q;
        if (state_q == ST_SHIFT) begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
            end
        end
        if (accept) begin
            shreg_d = (grant_id == SRC1) ? req1_data : req0_data;
            cnt_d   = '0;
            src_d   = grant_id;
            rr_d    = ~grant_id;
            state_d = ST_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            src_q   <= SRC0;
            rr_q    <= SRC0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

    assign sout       = shreg_q[0];
    assign sout_valid = (state_q == ST_SHIFT);
    assign busy       = (state_q == ST_SHIFT);
    assign sout_first = (state_q == ST_SHIFT) && (cnt_q == '0);
    assign sout_last  = at_last;
    assign sout_src   = src_q;

endmodule
